// File: rtl/ddr2_sdram_ex_pkg.sv
// Shared types and helpers for the DDR2 example-design pattern controller.
package ddr2_sdram_ex_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_DATA,
    RD_INIT,
    RD_REQ,
    RD_WAIT,
    DONE
  } ex_state_e;

  // Galois feedback: bit 7 folds into bits 0, 2, 3 and 4.
  localparam logic [7:0] LFSR_TAPS = 8'h1D;

  function automatic int num_lanes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/ddr2_sdram_ex_pattern_lane.sv
// One byte lane: write-pattern LFSR, expected-data LFSR and byte comparator.
module ddr2_sdram_ex_pattern_lane
  import ddr2_sdram_ex_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_load_i,
  input  logic       wr_step_i,
  input  logic       exp_load_i,
  input  logic       exp_step_i,
  input  logic [7:0] rdata_i,
  output logic [7:0] wdata_o,
  output logic       match_o
);

  logic [7:0] wr_q;
  logic [7:0] exp_q;

  // Load wins over step so a restart always begins from the seed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= SEED;
      exp_q <= SEED;
    end else begin
      if (wr_load_i)      wr_q <= SEED;
      else if (wr_step_i) wr_q <= lfsr_next(wr_q);

      if (exp_load_i)      exp_q <= SEED;
      else if (exp_step_i) exp_q <= lfsr_next(exp_q);
    end
  end

  assign wdata_o = wr_q;
  assign match_o = (rdata_i == exp_q);

endmodule

// File: rtl/ddr2_sdram_ex_pattern_ctl.sv
// DDR2 example-design self-test controller: LFSR write phase, then read-back compare.
// Optional write-beat error injection when DDR2_EX_PATTERN_CTL_ERR_INJECT_EN is defined.
module ddr2_sdram_ex_pattern_ctl
  import ddr2_sdram_ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN  = 4,
  parameter int NUM_BURSTS = 16,
  parameter int SEED_BASE  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    local_ready,
  output logic                    local_write_req,
  output logic                    local_read_req,
  output logic [ADDR_WIDTH-1:0]   local_addr,
  output logic [3:0]              local_size,
  input  logic                    local_wdata_req,
  output logic [DATA_WIDTH-1:0]   local_wdata,
  input  logic [DATA_WIDTH-1:0]   local_rdata,
  input  logic                    local_rdata_valid,
`ifdef DDR2_EX_PATTERN_CTL_ERR_INJECT_EN
  input  logic                    err_inject,
`endif
  output logic                    busy,
  output logic                    test_complete,
  output logic [DATA_WIDTH/8-1:0] pnf_per_byte,
  output logic                    pass
);

  localparam int LANES       = num_lanes(DATA_WIDTH);
  localparam int TOTAL_BEATS = NUM_BURSTS * BURST_LEN;
  localparam int BURST_W     = $clog2(NUM_BURSTS) + 1;
  localparam int BEAT_W      = $clog2(BURST_LEN) + 1;
  localparam int RD_BEAT_W   = $clog2(TOTAL_BEATS) + 1;

  ex_state_e               state_q;
  logic [BURST_W-1:0]      wr_burst_cnt_q;
  logic [BURST_W-1:0]      rd_burst_cnt_q;
  logic [BEAT_W-1:0]       beat_cnt_q;
  logic [RD_BEAT_W-1:0]    rd_beat_cnt_q;
  logic                    write_req_q;
  logic                    read_req_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    busy_q;
  logic                    done_q;
  logic [LANES-1:0]        pnf_q;

  logic                    start_go;
  logic                    wr_beat;
  logic                    rd_beat;
  logic                    exp_load;
  logic [DATA_WIDTH-1:0]   lane_wdata;
  logic [LANES-1:0]        lane_match;

  assign start_go = start && ((state_q == IDLE) || (state_q == DONE));
  assign wr_beat  = (state_q == WR_DATA) && local_wdata_req;
  assign rd_beat  = ((state_q == RD_REQ) || (state_q == RD_WAIT)) && local_rdata_valid &&
                    (rd_beat_cnt_q < RD_BEAT_W'(TOTAL_BEATS));
  assign exp_load = start_go || (state_q == RD_INIT);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ddr2_sdram_ex_pattern_lane #(
      .SEED(8'((SEED_BASE + i) % 256))
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_load_i  (start_go),
      .wr_step_i  (wr_beat),
      .exp_load_i (exp_load),
      .exp_step_i (rd_beat),
      .rdata_i    (local_rdata[8*i +: 8]),
      .wdata_o    (lane_wdata[8*i +: 8]),
      .match_o    (lane_match[i])
    );
  end

  // NOTE: all state here uses non-blocking assignment so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wr_burst_cnt_q <= '0;
      rd_burst_cnt_q <= '0;
      beat_cnt_q     <= '0;
      rd_beat_cnt_q  <= '0;
      write_req_q    <= 1'b0;
      read_req_q     <= 1'b0;
      addr_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pnf_q          <= '1;
    end else begin
      // Read beats are scored in both RD_REQ and RD_WAIT.
      if (rd_beat) begin
        rd_beat_cnt_q <= rd_beat_cnt_q + 1'b1;
        pnf_q         <= pnf_q & lane_match;
      end

      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q        <= WR_REQ;
            write_req_q    <= 1'b1;
            addr_q         <= '0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            pnf_q          <= '1;
            wr_burst_cnt_q <= '0;
            rd_burst_cnt_q <= '0;
            beat_cnt_q     <= '0;
            rd_beat_cnt_q  <= '0;
          end
        end
        WR_REQ: begin
          if (local_ready) begin
            write_req_q    <= 1'b0;
            wr_burst_cnt_q <= wr_burst_cnt_q + 1'b1;
            beat_cnt_q     <= '0;
            state_q        <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (local_wdata_req) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == BEAT_W'(BURST_LEN - 1)) begin
              if (wr_burst_cnt_q < BURST_W'(NUM_BURSTS)) begin
                state_q     <= WR_REQ;
                write_req_q <= 1'b1;
                addr_q      <= ADDR_WIDTH'(wr_burst_cnt_q) * ADDR_WIDTH'(BURST_LEN);
              end else begin
                state_q <= RD_INIT;
              end
            end
          end
        end
        RD_INIT: begin
          state_q        <= RD_REQ;
          read_req_q     <= 1'b1;
          addr_q         <= '0;
          rd_burst_cnt_q <= '0;
        end
        RD_REQ: begin
          if (local_ready) begin
            rd_burst_cnt_q <= rd_burst_cnt_q + 1'b1;
            if (rd_burst_cnt_q == BURST_W'(NUM_BURSTS - 1)) begin
              read_req_q <= 1'b0;
              state_q    <= RD_WAIT;
            end else begin
              addr_q <= ADDR_WIDTH'(rd_burst_cnt_q + 1'b1) * ADDR_WIDTH'(BURST_LEN);
            end
          end
        end
        RD_WAIT: begin
          if (rd_beat_cnt_q == RD_BEAT_W'(TOTAL_BEATS)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DDR2_EX_PATTERN_CTL_ERR_INJECT_EN
  // Corrupt only the driven beat; lane state keeps the clean sequence.
  assign local_wdata = lane_wdata ^ {{(DATA_WIDTH-1){1'b0}}, err_inject & wr_beat};
`else
  assign local_wdata = lane_wdata;
`endif

  assign local_write_req = write_req_q;
  assign local_read_req  = read_req_q;
  assign local_addr      = addr_q;
  assign local_size      = 4'(BURST_LEN);
  assign busy            = busy_q;
  assign test_complete   = done_q;
  assign pnf_per_byte    = pnf_q;
  assign pass            = done_q & (&pnf_q);

endmodule

// File: tb/tb_ddr2_sdram_ex_pattern_ctl.sv
// Bench for ddr2_sdram_ex_pattern_ctl: scenario table driven through a reactive memory model.
// Covers DDR2_EX_PATTERN_CTL_ERR_INJECT_EN when the bench is built with that macro.
module tb_ddr2_sdram_ex_pattern_ctl;

  localparam int DW    = 32;
  localparam int AW    = 24;
  localparam int BL    = 4;
  localparam int NB    = 16;
  localparam int SB    = 32;
  localparam int LANES = DW / 8;
  localparam int TOTAL = NB * BL;
  localparam int MAX_CYCLES = 4000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          local_ready = 1'b0;
  logic          local_wdata_req = 1'b0;
  logic          local_rdata_valid = 1'b0;
  logic [DW-1:0] local_rdata = '0;
  logic          local_write_req;
  logic          local_read_req;
  logic [AW-1:0] local_addr;
  logic [3:0]    local_size;
  logic [DW-1:0] local_wdata;
  logic          busy;
  logic          test_complete;
  logic [LANES-1:0] pnf_per_byte;
  logic          pass;
`ifdef DDR2_EX_PATTERN_CTL_ERR_INJECT_EN
  logic          err_inject = 1'b0;
`endif

  always #5 clk = ~clk;

  ddr2_sdram_ex_pattern_ctl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .local_ready       (local_ready),
    .local_write_req   (local_write_req),
    .local_read_req    (local_read_req),
    .local_addr        (local_addr),
    .local_size        (local_size),
    .local_wdata_req   (local_wdata_req),
    .local_wdata       (local_wdata),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
`ifdef DDR2_EX_PATTERN_CTL_ERR_INJECT_EN
    .err_inject        (err_inject),
`endif
    .busy              (busy),
    .test_complete     (test_complete),
    .pnf_per_byte      (pnf_per_byte),
    .pass              (pass)
  );

  typedef struct {
    int         ready_pct;
    int         gap_pct;
    int         corrupt_beat;
    int         corrupt_byte;
    int         inject_beat;
    bit         poke_rd_wait;
    logic [3:0] exp_pnf;
    logic       exp_pass;
  } vec_t;

  vec_t          vecs[$];
  int            n_checks;
  int            n_pass;
  logic [DW-1:0] mem [TOTAL];
  int            rd_q[$];
  logic [DW-1:0] first_beat;
  logic [DW-1:0] second_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Beat k of the pattern: each lane is its seed multiplied by x^k in GF(2^8) mod 0x11D.
  function automatic logic [DW-1:0] pattern(input int beat);
    logic [DW-1:0] w;
    int s;
    w = '0;
    for (int i = 0; i < LANES; i++) begin
      s = (SB + i) % 256;
      for (int k = 0; k < beat; k++) begin
        s = s * 2;
        if (s >= 256) s = s ^ 'h11D;
      end
      w[8*i +: 8] = 8'(s);
    end
    return w;
  endfunction

  task automatic run_test(input vec_t v, input int abort_burst);
    int wr_bursts, rd_bursts, wr_pend, wr_base, wr_beats, rd_beats, a, idx;
    logic [LANES-1:0] exp_pnf;
    bit stall_prev, poked, poke_pending, aborted, do_wr;
    logic [1:0] prev_req;
    logic [AW-1:0] prev_addr, poke_addr;
    logic [DW-1:0] exp_w, d;

    wr_bursts = 0; rd_bursts = 0; wr_pend = 0; wr_base = 0; wr_beats = 0; rd_beats = 0;
    exp_pnf = '1; stall_prev = 0; poked = 0; poke_pending = 0; aborted = 0;
    prev_req = '0; prev_addr = '0; poke_addr = '0;
    rd_q.delete();

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("pnf_after_start", 64'(pnf_per_byte), 64'hF);
    check("complete_after_start", 64'(test_complete), 64'd0);

    for (int cyc = 0; cyc < MAX_CYCLES; cyc++) begin
      if (poke_pending) begin
        start = 1'b0;
        poke_pending = 0;
        check("rd_wait_start_addr", 64'(local_addr), 64'(poke_addr));
        check("rd_wait_start_busy", 64'(busy), 64'd1);
        check("rd_wait_start_wreq", 64'(local_write_req), 64'd0);
      end
      if (test_complete) break;

      if (abort_burst >= 0 && wr_bursts == abort_burst + 1 && wr_pend > 0 && wr_pend < BL) begin
        local_ready = 1'b0; local_wdata_req = 1'b0; local_rdata_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_write_req", 64'(local_write_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(local_addr), 64'd0);
        check("rst_wdata", 64'(local_wdata), 64'h23222120);
        check("rst_pnf", 64'(pnf_per_byte), 64'hF);
        check("rst_pass", 64'(pass), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        aborted = 1;
        break;
      end

      if (stall_prev) begin
        check("hold_req", 64'({local_write_req, local_read_req}), 64'(prev_req));
        check("hold_addr", 64'(local_addr), 64'(prev_addr));
      end

      local_wdata_req = 1'b0;
`ifdef DDR2_EX_PATTERN_CTL_ERR_INJECT_EN
      err_inject = 1'b0;
`endif
      do_wr = (wr_pend > 0) && (int'($urandom_range(99)) >= v.gap_pct);
      if (do_wr) begin
        local_wdata_req = 1'b1;
`ifdef DDR2_EX_PATTERN_CTL_ERR_INJECT_EN
        if (wr_beats == v.inject_beat) err_inject = 1'b1;
`endif
      end

      local_rdata_valid = 1'b0;
      if (rd_q.size() > 0 && int'($urandom_range(99)) >= v.gap_pct) begin
        a = rd_q.pop_front();
        d = (a >= 0 && a < TOTAL) ? mem[a] : '0;
        if (rd_beats == v.corrupt_beat) d = d ^ (DW'(32'hA5) << (8 * v.corrupt_byte));
        exp_w = pattern(rd_beats);
        for (int i = 0; i < LANES; i++)
          if (d[8*i +: 8] != exp_w[8*i +: 8]) exp_pnf[i] = 1'b0;
        local_rdata = d;
        local_rdata_valid = 1'b1;
        rd_beats++;
      end

      local_ready = (int'($urandom_range(99)) < v.ready_pct);
      if (local_write_req && local_ready) begin
        check("wr_addr", 64'(local_addr), 64'(wr_bursts * BL));
        wr_base = int'(local_addr);
        wr_pend = BL;
        wr_bursts++;
      end
      if (local_read_req && local_ready) begin
        check("rd_addr", 64'(local_addr), 64'(rd_bursts * BL));
        for (int k = 0; k < BL; k++) rd_q.push_back(int'(local_addr) + k);
        rd_bursts++;
      end
      stall_prev = (local_write_req || local_read_req) && !local_ready;
      prev_req   = {local_write_req, local_read_req};
      prev_addr  = local_addr;

      if (v.poke_rd_wait && !poked && rd_bursts == NB && !local_read_req && rd_q.size() > 0) begin
        start = 1'b1;
        poke_addr = local_addr;
        poked = 1;
        poke_pending = 1;
      end

      #1;
      if (do_wr) begin
        exp_w = pattern(wr_beats);
        if (wr_beats == v.inject_beat) exp_w[0] = ~exp_w[0];
        check("wdata", 64'(local_wdata), 64'(exp_w));
        idx = wr_base + BL - wr_pend;
        if (idx >= 0 && idx < TOTAL) mem[idx] = local_wdata;
        if (wr_beats == 0) first_beat = local_wdata;
        if (wr_beats == 1) second_beat = local_wdata;
        wr_pend--;
        wr_beats++;
      end
      @(negedge clk);
    end

    start = 1'b0; local_ready = 1'b0; local_wdata_req = 1'b0; local_rdata_valid = 1'b0;
`ifdef DDR2_EX_PATTERN_CTL_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    if (!aborted) begin
      check("test_complete", 64'(test_complete), 64'd1);
      check("pnf_model", 64'(pnf_per_byte), 64'(exp_pnf));
      check("pnf_table", 64'(pnf_per_byte), 64'(v.exp_pnf));
      check("pass", 64'(pass), 64'(v.exp_pass));
      check("busy_done", 64'(busy), 64'd0);
      check("wr_beat_total", 64'(wr_beats), 64'(TOTAL));
      check("rd_beat_total", 64'(rd_beats), 64'(TOTAL));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    vecs.push_back('{100, 0, -1, 0, -1, 1'b0, 4'hF, 1'b1});
    vecs.push_back('{50, 30, -1, 0, -1, 1'b1, 4'hF, 1'b1});
    vecs.push_back('{100, 0, 10, 2, -1, 1'b1, 4'hB, 1'b0});
    vecs.push_back('{70, 20, -1, 0, -1, 1'b0, 4'hF, 1'b1});
`ifdef DDR2_EX_PATTERN_CTL_ERR_INJECT_EN
    vecs.push_back('{100, 0, -1, 0, 0, 1'b0, 4'hE, 1'b0});
`endif

    repeat (3) @(negedge clk);
    check("reset_write_req", 64'(local_write_req), 64'd0);
    check("reset_read_req", 64'(local_read_req), 64'd0);
    check("reset_addr", 64'(local_addr), 64'd0);
    check("reset_size", 64'(local_size), 64'd4);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_complete", 64'(test_complete), 64'd0);
    check("reset_pass", 64'(pass), 64'd0);
    check("reset_pnf", 64'(pnf_per_byte), 64'hF);
    check("reset_wdata", 64'(local_wdata), 64'h23222120);
    reset_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      run_test(vecs[r], -1);
      if (r == 0) begin
        check("first_beat", 64'(first_beat), 64'h23222120);
        check("second_beat", 64'(second_beat), 64'h46444240);
      end
    end

    run_test(vecs[0], 5);
    check("busy_after_abort", 64'(busy), 64'd0);
    first_beat = '0;
    run_test(vecs[0], -1);
    check("first_beat_after_abort", 64'(first_beat), 64'h23222120);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
